// File: rtl/shift_unit_pipe_if.sv
// Handshake/data bundle for shift_unit_pipe.
//   Upstream  : i_valid / o_ready carry the operand (i_data, i_amt, i_mode, i_fill).
//   Downstream: o_valid / i_ready carry the result (o_data, o_carry, o_zero).
//   i_flush   : synchronous pipeline clear.
// The master modport is the side that drives operands and consumes results;
// the slave modport is the shift unit itself.
interface shift_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic [AMT_W-1:0] i_amt;
  logic [2:0]       i_mode;
  logic             i_fill;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_carry;
  logic             o_zero;

  modport master (
    output i_flush, i_valid, i_data, i_amt, i_mode, i_fill, i_ready,
    input  o_ready, o_valid, o_data, o_carry, o_zero
  );

  modport slave (
    input  i_flush, i_valid, i_data, i_amt, i_mode, i_fill, i_ready,
    output o_ready, o_valid, o_data, o_carry, o_zero
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined shift/rotate unit.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : shift_unit_pipe_if.slave (operand in, result out, flush)
// Stage A registers the operand; the shift result is computed from stage A
// and registered in stage B, which drives the outputs. Modes: LSL, LSR, ASR,
// ROL, ROR; reserved modes pass the operand through with carry 0.
module shift_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  shift_unit_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_LSL = 3'b000,
    MODE_LSR = 3'b001,
    MODE_ASR = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_e;

  localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

  // Stage A: operand register
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic [AMT_W-1:0] a_amt;
  mode_e            a_mode;
  logic             a_fill;

  // Stage B: result register
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_carry;
  logic             b_zero;

  logic b_free, a_load, a_to_b;

  assign b_free      = !b_valid || bus.i_ready;
  assign bus.o_ready = !a_valid || b_free;
  assign a_load      = bus.i_valid && bus.o_ready;
  assign a_to_b      = a_valid && b_free;

  // Shift datapath
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             sh_fill;
  logic [WIDTH:0]   lsl_val, lsr_val, fill_lo, fill_hi;
  logic [AMT_W-1:0] rot_n;
  logic [WIDTH-1:0] rol_val, ror_val;

  always_comb begin
    res_data  = a_data;
    res_carry = 1'b0;
    sh_fill   = (a_mode == MODE_ASR) ? a_data[WIDTH-1] : a_fill;
    // One extra bit above (LSL) or below (LSR) the operand catches the last
    // bit shifted out; the fill masks cover the vacated positions for n <= W.
    fill_lo   = sh_fill ? ~({(WIDTH+1){1'b1}} << a_amt) : '0;
    fill_hi   = sh_fill ? ~({(WIDTH+1){1'b1}} >> a_amt) : '0;
    lsl_val   = ({1'b0, a_data} << a_amt) | fill_lo;
    lsr_val   = ({a_data, 1'b0} >> a_amt) | fill_hi;
    rot_n     = a_amt % W_AMT;
    // Shift by W_AMT yields zero, so rot_n == 0 leaves the operand intact.
    rol_val   = (a_data << rot_n) | (a_data >> (W_AMT - rot_n));
    ror_val   = (a_data >> rot_n) | (a_data << (W_AMT - rot_n));
    if (a_amt != '0) begin
      case (a_mode)
        MODE_LSL: begin
          if (a_amt > W_AMT) begin
            res_data  = {WIDTH{sh_fill}};
            res_carry = sh_fill;
          end else begin
            res_data  = lsl_val[WIDTH-1:0];
            res_carry = lsl_val[WIDTH];
          end
        end
        MODE_LSR, MODE_ASR: begin
          if (a_amt > W_AMT) begin
            res_data  = {WIDTH{sh_fill}};
            res_carry = sh_fill;
          end else begin
            res_data  = lsr_val[WIDTH:1];
            res_carry = lsr_val[0];
          end
        end
        MODE_ROL: begin
          res_data  = rol_val;
          res_carry = rol_val[0];
        end
        MODE_ROR: begin
          res_data  = ror_val;
          res_carry = ror_val[WIDTH-1];
        end
        default: begin
          res_data  = a_data;
          res_carry = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_amt   <= '0;
      a_mode  <= MODE_LSL;
      a_fill  <= 1'b0;
      b_valid <= 1'b0;
      b_data  <= '0;
      b_carry <= 1'b0;
      b_zero  <= 1'b1;
    end else if (bus.i_flush) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      a_valid <= a_load || (a_valid && !b_free);
      b_valid <= a_to_b || (b_valid && !bus.i_ready);
      if (a_load) begin
        a_data <= bus.i_data;
        a_amt  <= bus.i_amt;
        a_mode <= mode_e'(bus.i_mode);
        a_fill <= bus.i_fill;
      end
      if (a_to_b) begin
        b_data  <= res_data;
        b_carry <= res_carry;
        b_zero  <= (res_data == '0);
      end
    end
  end

  assign bus.o_valid = b_valid;
  assign bus.o_data  = b_data;
  assign bus.o_carry = b_carry;
  assign bus.o_zero  = b_zero;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe (WIDTH 8, AMT_W 4). Expected results
// {zero, carry, data} are queued on operand acceptance and compared on output.
module tb_shift_unit_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;

  shift_unit_pipe_if #(.WIDTH(8), .AMT_W(4)) bus ();

  shift_unit_pipe #(.WIDTH(8), .AMT_W(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [9:0] exp_q[$];
  logic [9:0] cur_exp;
  logic [9:0] popped;
  bit         rec_en = 1'b0;
  int         pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bit-serial reference: applies n single-bit steps.
  function automatic logic [9:0] model(input logic [2:0] m, input logic [7:0] d,
                                       input logic [3:0] n, input logic f);
    logic [7:0] r = d;
    logic       c = 1'b0;
    if (m <= 3'd4) begin
      for (int unsigned i = 0; i < n; i++) begin
        case (m)
          3'd0: begin c = r[7]; r = {r[6:0], f}; end
          3'd1: begin c = r[0]; r = {f, r[7:1]}; end
          3'd2: begin c = r[0]; r = {r[7], r[7:1]}; end
          3'd3: begin r = {r[6:0], r[7]}; c = r[0]; end
          default: begin r = {r[0], r[7:1]}; c = r[7]; end
        endcase
      end
    end
    return {(r == 8'h00), c, r};
  endfunction

  // Scoreboard / monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check("o_ready", bus.o_ready, !(exp_q.size() == 2 && !bus.i_ready));
      if (bus.i_flush) begin
        exp_q.delete();
      end else begin
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", bus.o_valid, 0);
          end else begin
            popped = exp_q.pop_front();
            check("result", {bus.o_zero, bus.o_carry, bus.o_data}, popped);
            if (rec_en) pop_cyc.push_back(cyc);
          end
        end
        if (bus.i_valid && bus.o_ready) exp_q.push_back(cur_exp);
      end
    end
  end

  task automatic set_op(input logic [2:0] m, input logic [7:0] d, input logic [3:0] n,
                        input logic f, input logic [9:0] e);
    cur_exp     = e;
    bus.i_mode  = m;
    bus.i_data  = d;
    bus.i_amt   = n;
    bus.i_fill  = f;
    bus.i_valid = 1'b1;
  endtask

  // Offer an operand and hold it until accepted; leaves i_valid high.
  task automatic drive(input logic [2:0] m, input logic [7:0] d, input logic [3:0] n,
                       input logic f, input logic [9:0] e);
    bit acc = 1'b0;
    set_op(m, d, n, f, e);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.o_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", bus.o_ready, 1);
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Offer into an empty pipeline with i_ready high and check two-cycle latency.
  task automatic latency_op(input logic [2:0] m, input logic [7:0] d, input logic [3:0] n,
                            input logic f, input logic [9:0] e);
    bus.i_ready = 1'b1;
    set_op(m, d, n, f, e);
    @(posedge clk);
    #1;
    idle();
    check("lat_edge_k", bus.o_valid, 0);
    @(posedge clk);
    #1;
    check("lat_edge_k1", bus.o_valid, 1);
    drain();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2:0] m;
    logic [7:0] d;
    logic [3:0] n;
    logic       f;

    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_data  = '0;
    bus.i_amt   = '0;
    bus.i_mode  = '0;
    bus.i_fill  = 1'b0;
    cur_exp     = '0;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_data",  bus.o_data,  0);
    check("rst_o_carry", bus.o_carry, 0);
    check("rst_o_zero",  bus.o_zero,  1);
    check("rst_o_ready", bus.o_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic shifts with latency check
    latency_op(3'b000, 8'hB5, 4'd3, 1'b0, 10'h1A8);
    drive(3'b001, 8'hB5, 4'd2,  1'b1, 10'h0ED);
    drive(3'b010, 8'h80, 4'd9,  1'b0, 10'h1FF);
    drive(3'b011, 8'hB5, 4'd11, 1'b0, 10'h1AD);
    drive(3'b000, 8'h01, 4'd8,  1'b0, 10'h300);
    drive(3'b110, 8'h3C, 4'd5,  1'b1, 10'h03C);
    drive(3'b100, 8'hB5, 4'd3,  1'b0, 10'h1B6);
    drive(3'b001, 8'hB5, 4'd0,  1'b1, 10'h0B5);
    drive(3'b001, 8'h5A, 4'd15, 1'b1, 10'h1FF);
    drive(3'b000, 8'h5A, 4'd9,  1'b0, 10'h200);
    idle();
    drain();

    // Backpressure: stall three edges with both stages full
    bus.i_ready = 1'b1;
    drive(3'b000, 8'h11, 4'd1, 1'b0, 10'h022);
    drive(3'b001, 8'hF0, 4'd4, 1'b0, 10'h00F);
    bus.i_ready = 1'b0;
    set_op(3'b011, 8'h81, 4'd1, 1'b0, model(3'b011, 8'h81, 4'd1, 1'b0));
    repeat (3) begin
      @(negedge clk);
      check("bp_ready", bus.o_ready, 0);
      check("bp_valid", bus.o_valid, 1);
      check("bp_hold",  bus.o_data,  8'h22);
      @(posedge clk);
      #1;
    end
    bus.i_ready = 1'b1;
    drive(3'b011, 8'h81, 4'd1, 1'b0, model(3'b011, 8'h81, 4'd1, 1'b0));
    drive(3'b010, 8'h90, 4'd3, 1'b0, model(3'b010, 8'h90, 4'd3, 1'b0));
    idle();
    drain();

    // Full-throughput random streaming
    pop_cyc.delete();
    rec_en = 1'b1;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      m = 3'($urandom_range(0, 4));
      d = 8'($urandom);
      n = 4'($urandom);
      f = 1'($urandom);
      drive(m, d, n, f, model(m, d, n, f));
    end
    idle();
    drain();
    rec_en = 1'b0;
    check("stream_count", pop_cyc.size(), 16);
    if (pop_cyc.size() == 16) check("stream_span", pop_cyc[15] - pop_cyc[0], 15);

    // Flush with both stages full and a new operand offered
    bus.i_ready = 1'b0;
    drive(3'b000, 8'h0F, 4'd2, 1'b0, model(3'b000, 8'h0F, 4'd2, 1'b0));
    drive(3'b001, 8'hF0, 4'd2, 1'b0, model(3'b001, 8'hF0, 4'd2, 1'b0));
    set_op(3'b100, 8'h77, 4'd1, 1'b0, model(3'b100, 8'h77, 4'd1, 1'b0));
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    idle();
    check("flush_o_valid", bus.o_valid, 0);
    check("flush_o_ready", bus.o_ready, 1);
    bus.i_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flush_dropped", bus.o_valid, 0);
    end
    @(posedge clk);
    #1;
    latency_op(3'b010, 8'hC3, 4'd2, 1'b0, model(3'b010, 8'hC3, 4'd2, 1'b0));

    // Asynchronous reset while stalled with a valid result
    bus.i_ready = 1'b0;
    drive(3'b000, 8'hFF, 4'd1, 1'b0, model(3'b000, 8'hFF, 4'd1, 1'b0));
    drive(3'b001, 8'hFF, 4'd1, 1'b0, model(3'b001, 8'hFF, 4'd1, 1'b0));
    idle();
    check("pre_rst_o_valid", bus.o_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_o_valid", bus.o_valid, 0);
    check("arst_o_data",  bus.o_data,  0);
    check("arst_o_carry", bus.o_carry, 0);
    check("arst_o_zero",  bus.o_zero,  1);
    check("arst_o_ready", bus.o_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    latency_op(3'b011, 8'h96, 4'd4, 1'b0, model(3'b011, 8'h96, 4'd4, 1'b0));
    repeat (3) begin
      @(negedge clk);
      check("post_rst_empty", bus.o_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
